// File: rtl/mips_mem_responder.sv
// Byte-wide unified memory responder for the processor bus.
// Loader fills storage, then reads/writes are served with fixed latency.
module mips_mem_responder #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] memdata,
    output logic             memready,
    input  logic             ld_valid,
    input  logic [WIDTH-1:0] ld_adr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_done,
    output logic             ld_ready,
    output logic             run,
    output logic             err
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        IDLE  = 2'd1,
        RBUSY = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       cnt;
    logic [WIDTH-1:0] radr;
    logic [WIDTH-1:0] mem [0:(2**WIDTH)-1];

    logic             ld_wr;
    logic             cpu_wr;

    assign ld_wr  = (state == LOAD) && ld_valid;
    assign cpu_wr = (state == IDLE) && memwrite;

    // Storage write port; deliberately not reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_wr) begin
            mem[ld_adr] <= ld_data;
        end else if (cpu_wr) begin
            mem[adr] <= writedata;
        end
    end

    // Control FSM with registered response, handshake and error outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= LOAD;
            memdata  <= '0;
            memready <= 1'b0;
            ld_ready <= 1'b1;
            run      <= 1'b0;
            err      <= 1'b0;
            cnt      <= '0;
            radr     <= '0;
        end else begin
            memready <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (memread || memwrite) begin
                        err <= 1'b1;
                    end
                    if (ld_done) begin
                        state    <= IDLE;
                        ld_ready <= 1'b0;
                        run      <= 1'b1;
                    end
                end
                IDLE: begin
                    if (memwrite) begin
                        memready <= 1'b1;
                        if (memread) begin
                            memdata <= writedata;
                            err     <= 1'b1;
                        end
                    end else if (memread) begin
                        if (LATENCY == 1) begin
                            memdata  <= mem[adr];
                            memready <= 1'b1;
                        end else begin
                            radr  <= adr;
                            cnt   <= 2'(LATENCY - 1);
                            state <= RBUSY;
                        end
                    end
                end
                RBUSY: begin
                    if (memread || memwrite) begin
                        err <= 1'b1;
                    end
                    cnt <= cnt - 2'd1;
                    if (cnt <= 2'd1) begin
                        memdata  <= mem[radr];
                        memready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule
